// File: rtl/datapath_sequencer.sv
// Command sequencer and sole master of the regfile + ALU datapath.
// Runs one command at a time from a valid/ready command port to a valid/ready response port.
//
// state | meaning
// IDLE  | cmd_ready high; command fields latched on accept
// EXEC  | rs/rt/fn driven to the datapath; ALU result and zero flag captured
// WB    | single-cycle RegWrite of result_q into rd
// RESP  | resp_valid high; result held until resp_ready
module datapath_sequencer #(
    parameter int  Nloc  = 32,
    parameter int  Dbits = 32,
    parameter int  Cbits = 16,
    localparam int Abits = $clog2(Nloc)
) (
    input  logic             clock_i,
    input  logic             reset_i,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_kind_i,
    input  logic [4:0]       cmd_fn_i,
    input  logic [Abits-1:0] cmd_rs_i,
    input  logic [Abits-1:0] cmd_rt_i,
    input  logic [Abits-1:0] cmd_rd_i,
    input  logic [Dbits-1:0] cmd_imm_i,

    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [Dbits-1:0] resp_result_o,
    output logic             resp_zero_o,
    output logic [Cbits-1:0] done_count_o,

    output logic             RegWrite_o,
    output logic [Abits-1:0] ReadAddr1_o,
    output logic [Abits-1:0] ReadAddr2_o,
    output logic [Abits-1:0] WriteAddr_o,
    output logic [4:0]       ALUFN_o,
    output logic [Dbits-1:0] WriteData_o,
    input  logic [Dbits-1:0] ALUResult_i,
    input  logic             FlagZ_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] KIND_NOP   = 2'b00;
    localparam logic [1:0] KIND_LOADI = 2'b01;
    localparam logic [1:0] KIND_ALU   = 2'b10;
    localparam logic [1:0] KIND_CMP   = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic [4:0]       fn_q, fn_d;
    logic [Abits-1:0] rs_q, rs_d;
    logic [Abits-1:0] rt_q, rt_d;
    logic [Abits-1:0] rd_q, rd_d;
    logic [Dbits-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [Cbits-1:0] done_q, done_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            kind_q   <= '0;
            fn_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            fn_q     <= fn_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    // Datapath outputs depend only on state and latched fields, so a reset
    // clears RegWrite the moment state_q returns to IDLE.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        fn_d         = fn_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        result_d     = result_q;
        zero_d       = zero_q;
        done_d       = done_q;

        cmd_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        RegWrite_o   = 1'b0;
        ReadAddr1_o  = '0;
        ReadAddr2_o  = '0;
        WriteAddr_o  = '0;
        ALUFN_o      = '0;
        WriteData_o  = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    kind_d = cmd_kind_i;
                    fn_d   = cmd_fn_i;
                    rs_d   = cmd_rs_i;
                    rt_d   = cmd_rt_i;
                    rd_d   = cmd_rd_i;
                    case (cmd_kind_i)
                        KIND_NOP: begin
                            result_d = '0;
                            zero_d   = 1'b1;
                            state_d  = S_RESP;
                        end
                        KIND_LOADI: begin
                            result_d = cmd_imm_i;
                            zero_d   = (cmd_imm_i == '0);
                            state_d  = S_WB;
                        end
                        KIND_ALU, KIND_CMP: begin
                            state_d = S_EXEC;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                ReadAddr1_o = rs_q;
                ReadAddr2_o = rt_q;
                ALUFN_o     = fn_q;
                result_d    = ALUResult_i;
                zero_d      = FlagZ_i;
                state_d     = (kind_q == KIND_CMP) ? S_RESP : S_WB;
            end
            S_WB: begin
                RegWrite_o  = 1'b1;
                WriteAddr_o = rd_q;
                WriteData_o = result_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    done_d  = done_q + Cbits'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign resp_result_o = result_q;
    assign resp_zero_o   = zero_q;
    assign done_count_o  = done_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a behavioural regfile + ALU model.
// A second instance with a 4-bit done counter covers the counter wrap.
module tb_datapath_sequencer;

    localparam logic [1:0] KIND_NOP   = 2'b00;
    localparam logic [1:0] KIND_LOADI = 2'b01;
    localparam logic [1:0] KIND_ALU   = 2'b10;
    localparam logic [1:0] KIND_CMP   = 2'b11;
    // ALU function codes understood by the model datapath below
    localparam logic [4:0] FN_ADD = 5'b00001;
    localparam logic [4:0] FN_SUB = 5'b00011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_kind  = '0;
    logic [4:0]  cmd_fn    = '0;
    logic [4:0]  cmd_rs    = '0;
    logic [4:0]  cmd_rt    = '0;
    logic [4:0]  cmd_rd    = '0;
    logic [31:0] cmd_imm   = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [15:0] done_count;
    logic        reg_write;
    logic [4:0]  ra1, ra2, wa, alufn;
    logic [31:0] wd, alu_res;
    logic        flag_z;

    logic        n_valid = 1'b0;
    logic        n_ready;
    logic [1:0]  n_kind  = KIND_NOP;
    logic [4:0]  n_fn    = '0;
    logic [4:0]  n_addr  = '0;
    logic [31:0] n_imm   = '0;
    logic        n_resp_valid;
    logic        n_resp_ready = 1'b1;
    logic [31:0] n_result;
    logic        n_zero;
    logic [3:0]  n_done;
    logic        n_reg_write;
    logic [4:0]  n_ra1, n_ra2, n_wa, n_alufn;
    logic [31:0] n_wd;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          n_wr_cnt = 0;
    logic [15:0] exp_done = '0;

    always #5 clk = ~clk;

    datapath_sequencer u_dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_kind_i   (cmd_kind),
        .cmd_fn_i     (cmd_fn),
        .cmd_rs_i     (cmd_rs),
        .cmd_rt_i     (cmd_rt),
        .cmd_rd_i     (cmd_rd),
        .cmd_imm_i    (cmd_imm),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_result_o(resp_result),
        .resp_zero_o  (resp_zero),
        .done_count_o (done_count),
        .RegWrite_o   (reg_write),
        .ReadAddr1_o  (ra1),
        .ReadAddr2_o  (ra2),
        .WriteAddr_o  (wa),
        .ALUFN_o      (alufn),
        .WriteData_o  (wd),
        .ALUResult_i  (alu_res),
        .FlagZ_i      (flag_z)
    );

    datapath_sequencer #(.Cbits(4)) u_dut4 (
        .clock_i      (clk),
        .reset_i      (rst),
        .cmd_valid_i  (n_valid),
        .cmd_ready_o  (n_ready),
        .cmd_kind_i   (n_kind),
        .cmd_fn_i     (n_fn),
        .cmd_rs_i     (n_addr),
        .cmd_rt_i     (n_addr),
        .cmd_rd_i     (n_addr),
        .cmd_imm_i    (n_imm),
        .resp_valid_o (n_resp_valid),
        .resp_ready_i (n_resp_ready),
        .resp_result_o(n_result),
        .resp_zero_o  (n_zero),
        .done_count_o (n_done),
        .RegWrite_o   (n_reg_write),
        .ReadAddr1_o  (n_ra1),
        .ReadAddr2_o  (n_ra2),
        .WriteAddr_o  (n_wa),
        .ALUFN_o      (n_alufn),
        .WriteData_o  (n_wd),
        .ALUResult_i  (32'h0),
        .FlagZ_i      (1'b0)
    );

    // Datapath model: register 0 always reads 0, writes on the rising edge.
    logic [31:0] rf [32] = '{default: '0};
    logic [31:0] op_a, op_b;

    always_comb begin
        op_a = (ra1 == 5'd0) ? 32'h0 : rf[ra1];
        op_b = (ra2 == 5'd0) ? 32'h0 : rf[ra2];
        case (alufn)
            FN_ADD:  alu_res = op_a + op_b;
            FN_SUB:  alu_res = op_a - op_b;
            default: alu_res = 32'h0;
        endcase
        flag_z = (alu_res == 32'h0);
    end

    always @(posedge clk) begin
        if (reg_write) begin
            wr_cnt <= wr_cnt + 1;
            if (wa != 5'd0) rf[wa] <= wd;
        end
        if (n_reg_write) n_wr_cnt <= n_wr_cnt + 1;
    end

    task automatic issue(input logic [1:0] k, input logic [4:0] f, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind  = k;
        cmd_fn    = f;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_rd    = rd;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_kind  = ~k;
        cmd_fn    = ~f;
        cmd_rs    = ~rs;
        cmd_rt    = ~rt;
        cmd_rd    = ~rd;
        cmd_imm   = ~imm;
    endtask

    // lat counts rising edges from the accept edge (inclusive) to resp_valid.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_resp;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] k, input logic [4:0] f, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                           output int lat, output logic [31:0] res, output logic z,
                           output int wr, output logic [15:0] done);
        int w0;
        w0 = wr_cnt;
        issue(k, f, rs, rt, rd, imm);
        wait_resp(lat);
        res = resp_result;
        z   = resp_zero;
        take_resp;
        wr   = wr_cnt - w0;
        done = done_count;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b, expected 0", resp_valid); end
        n_checks++; if (resp_result !== 32'h0 || resp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %h/%b, expected 0/0", resp_result, resp_zero); end
        n_checks++; if (done_count !== 16'h0 || n_done !== 4'h0) begin n_fail++; $display("FAIL reset_done: got %h/%h, expected 0/0", done_count, n_done); end
        n_checks++; if ({reg_write, ra1, ra2, wa, alufn, wd} !== '0) begin n_fail++; $display("FAIL reset_datapath: got we=%b ra1=%h ra2=%h wa=%h fn=%h wd=%h, expected all 0", reg_write, ra1, ra2, wa, alufn, wd); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loadi_add;
        int lat, wr, w0;
        logic [31:0] res;
        logic z;
        logic [15:0] done;
        run_cmd(KIND_LOADI, 5'd0, 5'd0, 5'd0, 5'd1, 32'd5, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (lat !== 2 || res !== 32'd5 || z !== 1'b0) begin n_fail++; $display("FAIL loadi_r1: got lat=%0d res=%h z=%b, expected 2/5/0", lat, res, z); end
        n_checks++; if (wr !== 1 || done !== exp_done) begin n_fail++; $display("FAIL loadi_r1_write: got wr=%0d done=%0d, expected 1/%0d", wr, done, exp_done); end
        run_cmd(KIND_LOADI, 5'd0, 5'd0, 5'd0, 5'd2, 32'd3, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (lat !== 2 || res !== 32'd3 || wr !== 1) begin n_fail++; $display("FAIL loadi_r2: got lat=%0d res=%h wr=%0d, expected 2/3/1", lat, res, wr); end

        w0 = wr_cnt;
        issue(KIND_ALU, FN_ADD, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
        n_checks++; if (ra1 !== 5'd1 || ra2 !== 5'd2 || alufn !== FN_ADD || reg_write !== 1'b0) begin n_fail++; $display("FAIL add_exec_outputs: got ra1=%h ra2=%h fn=%h we=%b, expected 1/2/%h/0", ra1, ra2, alufn, reg_write, FN_ADD); end
        wait_resp(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d, expected 3", lat); end
        n_checks++; if (resp_result !== 32'd8 || resp_zero !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h/%b, expected 8/0", resp_result, resp_zero); end
        take_resp;
        exp_done++;
        n_checks++; if (wr_cnt - w0 !== 1 || rf[3] !== 32'd8) begin n_fail++; $display("FAIL add_writeback: got wr=%0d r3=%h, expected 1/8", wr_cnt - w0, rf[3]); end
        n_checks++; if (done_count !== exp_done || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL add_done: got done=%0d ready=%b, expected %0d/1", done_count, cmd_ready, exp_done); end
    endtask

    task automatic test_cmp;
        int lat, wr;
        logic [31:0] res;
        logic z;
        logic [15:0] done;
        run_cmd(KIND_CMP, FN_SUB, 5'd1, 5'd1, 5'd5, 32'h0, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (lat !== 2 || res !== 32'h0 || z !== 1'b1) begin n_fail++; $display("FAIL cmp_result: got lat=%0d res=%h z=%b, expected 2/0/1", lat, res, z); end
        n_checks++; if (wr !== 0 || done !== exp_done) begin n_fail++; $display("FAIL cmp_no_write: got wr=%0d done=%0d, expected 0/%0d", wr, done, exp_done); end
        run_cmd(KIND_ALU, FN_ADD, 5'd1, 5'd2, 5'd10, 32'h0, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (res !== 32'd8 || z !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL cmp_readback: got res=%h z=%b lat=%0d, expected 8/0/3", res, z, lat); end
    endtask

    task automatic test_r0;
        int lat, wr;
        logic [31:0] res;
        logic z;
        logic [15:0] done;
        run_cmd(KIND_LOADI, 5'd0, 5'd0, 5'd0, 5'd0, 32'd7, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (res !== 32'd7 || wr !== 1) begin n_fail++; $display("FAIL loadi_r0: got res=%h wr=%0d, expected 7/1", res, wr); end
        run_cmd(KIND_LOADI, 5'd0, 5'd0, 5'd0, 5'd4, 32'd9, lat, res, z, wr, done);
        exp_done++;
        run_cmd(KIND_ALU, FN_ADD, 5'd0, 5'd0, 5'd4, 32'h0, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (res !== 32'h0 || z !== 1'b1 || wr !== 1) begin n_fail++; $display("FAIL add_r0_r0: got res=%h z=%b wr=%0d, expected 0/1/1", res, z, wr); end
        run_cmd(KIND_ALU, FN_ADD, 5'd4, 5'd0, 5'd11, 32'h0, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (res !== 32'h0 || z !== 1'b1) begin n_fail++; $display("FAIL r4_readback: got res=%h z=%b, expected 0/1", res, z); end
        n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL r0_done: got %0d, expected %0d", done, exp_done); end
    endtask

    task automatic test_backpressure;
        int lat;
        issue(KIND_ALU, FN_SUB, 5'd2, 5'd1, 5'd7, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sub_latency: got %0d, expected 3", lat); end
        cmd_valid = 1'b1;
        cmd_kind  = KIND_NOP;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (resp_result !== 32'hFFFF_FFFE || resp_zero !== 1'b0) begin n_fail++; $display("FAIL hold_result[%0d]: got %h/%b, expected fffffffe/0", i, resp_result, resp_zero); end
            n_checks++; if (resp_valid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hold_handshake[%0d]: got valid=%b ready=%b, expected 1/0", i, resp_valid, cmd_ready); end
        end
        cmd_valid = 1'b0;
        n_checks++; if (done_count !== exp_done) begin n_fail++; $display("FAIL hold_done: got %0d, expected %0d", done_count, exp_done); end
        take_resp;
        exp_done++;
        n_checks++; if (done_count !== exp_done || cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL release: got done=%0d ready=%b valid=%b, expected %0d/1/0", done_count, cmd_ready, resp_valid, exp_done); end
        n_checks++; if (rf[7] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_writeback: got r7=%h, expected fffffffe", rf[7]); end
    endtask

    task automatic test_reset_mid_wb;
        int lat, wr, w0;
        logic [31:0] res;
        logic z;
        logic [15:0] done;
        run_cmd(KIND_LOADI, 5'd0, 5'd0, 5'd0, 5'd6, 32'd11, lat, res, z, wr, done);
        w0 = wr_cnt;
        issue(KIND_LOADI, 5'd0, 5'd0, 5'd0, 5'd6, 32'd40);
        n_checks++; if (reg_write !== 1'b1 || wa !== 5'd6 || wd !== 32'd40) begin n_fail++; $display("FAIL wb_outputs: got we=%b wa=%h wd=%h, expected 1/6/28", reg_write, wa, wd); end
        rst = 1'b1;
        #1;
        n_checks++; if (reg_write !== 1'b0 || wa !== 5'd0 || wd !== 32'h0) begin n_fail++; $display("FAIL reset_drops_write: got we=%b wa=%h wd=%h, expected 0/0/0", reg_write, wa, wd); end
        n_checks++; if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 || done_count !== 16'h0) begin n_fail++; $display("FAIL reset_mid_state: got ready=%b valid=%b done=%0d, expected 1/0/0", cmd_ready, resp_valid, done_count); end
        @(negedge clk);
        rst = 1'b0;
        exp_done = '0;
        n_checks++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL reset_no_write: got %0d writes, expected 0", wr_cnt - w0); end
        run_cmd(KIND_ALU, FN_ADD, 5'd6, 5'd0, 5'd12, 32'h0, lat, res, z, wr, done);
        exp_done++;
        n_checks++; if (res !== 32'd11 || z !== 1'b0) begin n_fail++; $display("FAIL r6_old_value: got %h/%b, expected b/0", res, z); end
        n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL post_reset_done: got %0d, expected %0d", done, exp_done); end
    endtask

    task automatic test_nop_wrap;
        logic [3:0] exp4;
        exp4 = '0;
        @(negedge clk);
        n_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (n_resp_valid !== 1'b1) begin n_fail++; $display("FAIL nop_latency[%0d]: got resp_valid=%b, expected 1", i, n_resp_valid); end
            n_checks++; if (n_result !== 32'h0 || n_zero !== 1'b1) begin n_fail++; $display("FAIL nop_resp[%0d]: got %h/%b, expected 0/1", i, n_result, n_zero); end
            @(posedge clk);
            #1;
            exp4 = (exp4 == 4'd15) ? 4'd0 : exp4 + 4'd1;
            n_checks++; if (n_done !== exp4 || n_ready !== 1'b1) begin n_fail++; $display("FAIL nop_done[%0d]: got done=%0d ready=%b, expected %0d/1", i, n_done, n_ready, exp4); end
            if (i == 17) n_valid = 1'b0;
        end
        n_checks++; if (n_done !== 4'd1) begin n_fail++; $display("FAIL nop_final_done: got %0d, expected 1", n_done); end
        n_checks++; if (n_wr_cnt !== 0 || {n_ra1, n_ra2, n_wa, n_alufn, n_wd} !== '0) begin n_fail++; $display("FAIL nop_datapath_idle: got writes=%0d ra1=%h ra2=%h wa=%h fn=%h wd=%h, expected all 0", n_wr_cnt, n_ra1, n_ra2, n_wa, n_alufn, n_wd); end
    endtask

    initial begin
        test_reset;
        test_loadi_add;
        test_cmp;
        test_r0;
        test_backpressure;
        test_reset_mid_wb;
        test_nop_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
